// File: rtl/accel_tilt_seq.sv
// accel_tilt_seq
// Sequences two CORDIC vectoring requests per accelerometer sample:
//   roll  = atan2(ay, az)
//   pitch = atan2(-ax, |(ay, az)|), reusing the roll request's magnitude.
// Publishes roll/pitch together with a one-cycle tilt_valid strobe.
// A per-request wait counter aborts a stalled CORDIC after TIMEOUT cycles.

module accel_tilt_seq #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        acc_valid,
   input  logic [15:0] acc_x,
   input  logic [15:0] acc_y,
   input  logic [15:0] acc_z,
   output logic        acc_ready,
   output logic        acc_overrun,
   output logic [23:0] crd_x,
   output logic [23:0] crd_y,
   output logic        crd_start,
   input  logic        crd_done,
   input  logic [23:0] crd_angle,
   input  logic [23:0] crd_magnitude,
   output logic [23:0] roll,
   output logic [23:0] pitch,
   output logic        tilt_valid,
   output logic        busy,
   output logic        err_timeout
);

   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ROLL_REQ   = 3'd1,
      ROLL_WAIT  = 3'd2,
      PITCH_REQ  = 3'd3,
      PITCH_WAIT = 3'd4
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [23:0]      ax_r;
   logic [23:0]      roll_l_r;
   logic [CNT_W-1:0] wait_cnt_r;

   logic accept_s;
   logic roll_done_s;
   logic pitch_done_s;
   logic expire_s;

   // Sign-extend a raw 16-bit accelerometer axis to the 24-bit CORDIC width.
   function automatic logic [23:0] sext16(input logic [15:0] v);
      return {{8{v[15]}}, v};
   endfunction

   // Decodes of the state register; overrun flags a sample arriving while busy.
   assign acc_ready   = (state_r == IDLE);
   assign busy        = (state_r != IDLE);
   assign crd_start   = (state_r == ROLL_REQ) || (state_r == PITCH_REQ);
   assign acc_overrun = acc_valid && (state_r != IDLE);

   // Next-state logic and per-cycle event strobes.
   always_comb begin
      state_s      = state_r;
      accept_s     = 1'b0;
      roll_done_s  = 1'b0;
      pitch_done_s = 1'b0;
      expire_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (acc_valid) begin
               accept_s = 1'b1;
               state_s  = ROLL_REQ;
            end else begin
               state_s  = IDLE;
            end
         end
         ROLL_REQ: begin
            state_s = ROLL_WAIT;
         end
         ROLL_WAIT: begin
            // A done arriving in the expiry cycle still counts as completion.
            if (crd_done) begin
               roll_done_s = 1'b1;
               state_s     = PITCH_REQ;
            end else if (wait_cnt_r == CNT_LAST) begin
               expire_s    = 1'b1;
               state_s     = IDLE;
            end else begin
               state_s     = ROLL_WAIT;
            end
         end
         PITCH_REQ: begin
            state_s = PITCH_WAIT;
         end
         PITCH_WAIT: begin
            if (crd_done) begin
               pitch_done_s = 1'b1;
               state_s      = IDLE;
            end else if (wait_cnt_r == CNT_LAST) begin
               expire_s     = 1'b1;
               state_s      = IDLE;
            end else begin
               state_s      = PITCH_WAIT;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Wait counter: cleared in each REQ cycle so it reads 0 in the first WAIT cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_cnt_r <= '0;
      end else if ((state_r == ROLL_REQ) || (state_r == PITCH_REQ)) begin
         wait_cnt_r <= '0;
      end else if ((state_r == ROLL_WAIT) || (state_r == PITCH_WAIT)) begin
         wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end else begin
         wait_cnt_r <= wait_cnt_r;
      end
   end

   // CORDIC operands are loaded on the edge entering each REQ state so they
   // are already valid while crd_start is high, and hold through the WAIT.
   // The roll magnitude goes straight into crd_x as the pitch request's X.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ax_r     <= 24'd0;
         roll_l_r <= 24'd0;
         crd_x    <= 24'd0;
         crd_y    <= 24'd0;
      end else if (accept_s) begin
         ax_r     <= sext16(acc_x);
         roll_l_r <= roll_l_r;
         crd_x    <= sext16(acc_z);
         crd_y    <= sext16(acc_y);
      end else if (roll_done_s) begin
         ax_r     <= ax_r;
         roll_l_r <= crd_angle;
         crd_x    <= crd_magnitude;
         // 24-bit negate: -(-32768) becomes +32768 without wrapping.
         crd_y    <= 24'd0 - ax_r;
      end else begin
         ax_r     <= ax_r;
         roll_l_r <= roll_l_r;
         crd_x    <= crd_x;
         crd_y    <= crd_y;
      end
   end

   // Published results: roll and pitch update together, strobes last one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         roll        <= 24'd0;
         pitch       <= 24'd0;
         tilt_valid  <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         tilt_valid  <= pitch_done_s;
         err_timeout <= expire_s;
         if (pitch_done_s) begin
            roll  <= roll_l_r;
            pitch <= crd_angle;
         end else begin
            roll  <= roll;
            pitch <= pitch;
         end
      end
   end

endmodule

// File: tb/tb_accel_tilt_seq.sv
// Scoreboard bench for accel_tilt_seq: a behavioural CORDIC responder, a
// stimulus process pushing expected requests/results, and a monitor popping
// and comparing whenever the DUT emits crd_start, tilt_valid, err_timeout
// or acc_overrun.

module tb_accel_tilt_seq;

   localparam int TMO    = 64;
   localparam int NO_OVR = 999;

   typedef struct {
      int kind;   // 0 = tilt result, 1 = timeout
      int roll;
      int rtol;
      int pitch;
      int ptol;
      int acc;
      int lat;
   } exp_t;

   typedef struct {
      int x;
      int xtol;
      int y;
   } req_t;

   logic        clk;
   logic        rst_n;
   logic        acc_valid;
   logic [15:0] acc_x, acc_y, acc_z;
   logic        acc_ready, acc_overrun;
   logic [23:0] crd_x, crd_y;
   logic        crd_start;
   logic        crd_done;
   logic [23:0] crd_angle, crd_magnitude;
   logic [23:0] roll, pitch;
   logic        tilt_valid, busy, err_timeout;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   ovr_lc = NO_OVR;
   int   ovr_cyc = -100;
   exp_t exp_q[$];
   req_t req_q[$];
   int   ovr_q[$];

   accel_tilt_seq #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .acc_valid(acc_valid),
      .acc_x(acc_x), .acc_y(acc_y), .acc_z(acc_z),
      .acc_ready(acc_ready), .acc_overrun(acc_overrun),
      .crd_x(crd_x), .crd_y(crd_y), .crd_start(crd_start),
      .crd_done(crd_done), .crd_angle(crd_angle), .crd_magnitude(crd_magnitude),
      .roll(roll), .pitch(pitch), .tilt_valid(tilt_valid),
      .busy(busy), .err_timeout(err_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: actual timeout, required finish");
      $fatal(1, "watchdog");
   end

   function automatic int s24(input logic [23:0] v);
      return int'($signed(v));
   endfunction

   // atan2 with the CORDIC's x-sign folding, in 131 counts per degree.
   function automatic int tilt_counts(input real y, input real x);
      real xa;
      if (y == 0.0 && x == 0.0) return 0;
      xa = (x < 0.0) ? -x : x;
      return int'($atan2(y, xa) * 180.0 / 3.141592653589793 * 131.0);
   endfunction

   function automatic real vec_len(input real a, input real b);
      return $sqrt(a * a + b * b);
   endfunction

   function automatic void chk(input string nm, input int act, input int exp, input int tol);
      n_cmp++;
      if ((act > exp + tol) || (act < exp - tol)) begin
         n_fail++;
         $display("FAIL %s: actual %0d, required %0d (tol %0d)", nm, act, exp, tol);
      end
   endfunction

   // Behavioural CORDIC: answers each request after Lc cycles (1 for a zero vector).
   initial begin : cordic_model
      int mx, my, lc;
      crd_done = 1'b0;
      crd_angle = 24'd0;
      crd_magnitude = 24'd0;
      forever begin
         @(negedge clk);
         if (rst_n && crd_start) begin
            mx = s24(crd_x);
            my = s24(crd_y);
            lc = (mx == 0 && my == 0) ? 1 : 16;
            if (cyc == ovr_cyc) lc = ovr_lc;
            if (lc >= 0) begin
               repeat (lc + 1) @(posedge clk);
               #1;
               crd_done      = 1'b1;
               crd_angle     = 24'(tilt_counts(real'(my), real'(mx)));
               crd_magnitude = 24'(int'(vec_len(real'(mx), real'(my))));
               @(posedge clk);
               #1;
               crd_done = 1'b0;
            end
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents an event.
   initial begin : monitor
      exp_t e;
      req_t r;
      int pub_roll, pub_pitch, pub_rtol, pub_ptol;
      pub_roll = 0; pub_pitch = 0; pub_rtol = 0; pub_ptol = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pub_roll = 0; pub_pitch = 0; pub_rtol = 0; pub_ptol = 0;
         end else begin
            if (crd_start) begin
               if (req_q.size() == 0) begin
                  chk("unexpected_crd_start", int'(crd_start), 0, 0);
               end else begin
                  r = req_q.pop_front();
                  chk("crd_x", s24(crd_x), r.x, r.xtol);
                  chk("crd_y", s24(crd_y), r.y, 0);
               end
            end
            if (acc_overrun) begin
               if (ovr_q.size() == 0) chk("unexpected_overrun", int'(acc_overrun), 0, 0);
               else chk("overrun_cycle", cyc, ovr_q.pop_front(), 0);
            end
            if (tilt_valid || err_timeout) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_tilt_valid", int'(tilt_valid), 0, 0);
                  chk("unexpected_err_timeout", int'(err_timeout), 0, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("tilt_valid", int'(tilt_valid), (e.kind == 0) ? 1 : 0, 0);
                  chk("err_timeout", int'(err_timeout), (e.kind == 1) ? 1 : 0, 0);
                  chk("latency", cyc - e.acc, e.lat, 0);
                  if (e.kind == 0) begin
                     chk("roll", s24(roll), e.roll, e.rtol);
                     chk("pitch", s24(pitch), e.pitch, e.ptol);
                     pub_roll = e.roll; pub_pitch = e.pitch;
                     pub_rtol = e.rtol; pub_ptol = e.ptol;
                  end else begin
                     chk("roll_held", s24(roll), pub_roll, pub_rtol);
                     chk("pitch_held", s24(pitch), pub_pitch, pub_ptol);
                  end
               end
            end
         end
      end
   end

   // Issue one sample and push its expected CORDIC requests and outcome.
   task automatic send(input int ax, input int ay, input int az, input int lc_ov,
                       input int kind, input int e_roll, input int e_rtol,
                       input int e_pitch, input int e_ptol, input int e_lat,
                       input int n_req, output int acc_at);
      exp_t e;
      req_t r;
      int w;
      w = 0;
      while (!acc_ready && w < 400) begin
         @(posedge clk); #1; w++;
      end
      chk("acc_ready_wait", int'(acc_ready), 1, 0);
      acc_at = cyc;
      if (acc_ready) begin
         r.x = az; r.xtol = 0; r.y = ay;
         req_q.push_back(r);
         if (n_req == 2) begin
            r.x = int'(vec_len(real'(ay), real'(az))); r.xtol = 1; r.y = -ax;
            req_q.push_back(r);
         end
         ovr_lc  = lc_ov;
         ovr_cyc = (lc_ov == NO_OVR) ? -100 : cyc + 1;
         acc_x = 16'(ax); acc_y = 16'(ay); acc_z = 16'(az);
         acc_valid = 1'b1;
         @(posedge clk); #1;
         acc_valid = 1'b0;
         acc_at = cyc;
         if (kind >= 0) begin
            e.kind = kind; e.roll = e_roll; e.rtol = e_rtol;
            e.pitch = e_pitch; e.ptol = e_ptol; e.acc = acc_at; e.lat = e_lat;
            exp_q.push_back(e);
         end
      end
   endtask

   // Reference expectations derived from atan2/hypot and the latency rule.
   task automatic run_ref(input int ax, input int ay, input int az, input int lc_ov,
                          output int acc_at);
      real m;
      int r_e, p_e, lr, lp;
      r_e = tilt_counts(real'(ay), real'(az));
      m   = vec_len(real'(ay), real'(az));
      p_e = tilt_counts(real'(-ax), m);
      lr  = (ay == 0 && az == 0) ? 1 : 16;
      if (lc_ov != NO_OVR) lr = lc_ov;
      lp  = (ax == 0 && m == 0.0) ? 1 : 16;
      send(ax, ay, az, lc_ov, 0, r_e, 2, p_e, 2, 4 + lr + lp, 2, acc_at);
   endtask

   initial begin : stimulus
      int k0, w;
      rst_n = 1'b0; acc_valid = 1'b0;
      acc_x = 16'd0; acc_y = 16'd0; acc_z = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_acc_ready", int'(acc_ready), 1, 0);
      chk("rst_busy", int'(busy), 0, 0);
      chk("rst_crd_start", int'(crd_start), 0, 0);
      chk("rst_tilt_valid", int'(tilt_valid), 0, 0);
      chk("rst_err_timeout", int'(err_timeout), 0, 0);
      chk("rst_acc_overrun", int'(acc_overrun), 0, 0);
      chk("rst_roll", s24(roll), 0, 0);
      chk("rst_pitch", s24(pitch), 0, 0);
      chk("rst_crd_x", s24(crd_x), 0, 0);
      chk("rst_crd_y", s24(crd_y), 0, 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Level, 45-degree roll, pure pitch (zero-vector first request).
      send(0, 0, 16384, NO_OVR, 0, 0, 3, 0, 3, 36, 2, k0);
      send(0, 11585, 11585, NO_OVR, 0, 5895, 4, 0, 3, 36, 2, k0);
      send(-16384, 0, 0, NO_OVR, 0, 0, 0, 11790, 8, 21, 2, k0);

      // Overrun during PITCH_WAIT: dropped sample, in-flight result intact.
      run_ref(2000, 3000, 15000, NO_OVR, k0);
      while (cyc < k0 + 25) begin @(posedge clk); #1; end
      chk("busy_before_overrun", int'(acc_ready), 0, 0);
      acc_x = 16'd1000; acc_y = 16'd500; acc_z = 16'd700;
      acc_valid = 1'b1;
      ovr_q.push_back(cyc);
      @(posedge clk); #1;
      acc_valid = 1'b0;
      run_ref(-5000, 7000, -9000, NO_OVR, k0);

      // Timeout: withheld done, done on the last wait cycle, done one cycle late.
      send(3000, 4000, 12000, -1, 1, 0, 0, 0, 0, TMO + 1, 1, k0);
      run_ref(3000, 4000, 12000, TMO - 1, k0);
      send(-7000, 1000, 2000, TMO, 1, 0, 0, 0, 0, TMO + 1, 1, k0);
      repeat (10) @(posedge clk);
      #1;

      // Reset during ROLL_WAIT aborts silently.
      send(1000, 2000, 3000, NO_OVR, -1, 0, 0, 0, 0, 0, 1, k0);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("midrst_busy", int'(busy), 0, 0);
      chk("midrst_acc_ready", int'(acc_ready), 1, 0);
      chk("midrst_roll", s24(roll), 0, 0);
      chk("midrst_pitch", s24(pitch), 0, 0);
      repeat (30) @(posedge clk);
      #1;

      // Randomized back-to-back samples, including full-scale negatives.
      for (int i = 0; i < 20; i++) begin
         int ax, ay, az;
         ax = int'($urandom_range(65535)) - 32768;
         ay = int'($urandom_range(65535)) - 32768;
         az = int'($urandom_range(65535)) - 32768;
         if (i == 3) ax = -32768;
         if (i == 7) begin ay = -32768; az = -32768; end
         if (i == 11) begin ay = 0; az = 0; end
         run_ref(ax, ay, az, NO_OVR, k0);
      end

      w = 0;
      while ((exp_q.size() + req_q.size() + ovr_q.size()) != 0 && w < 500) begin
         @(posedge clk); #1; w++;
      end
      chk("scoreboard_drained", exp_q.size() + req_q.size() + ovr_q.size(), 0, 0);
      repeat (5) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
